dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Load/store initiator that sits between the CPU core's execute stage and data memory.
- Accepts one load or store at a time from the core over a valid/ready handshake.
- Drives the data memory's memread/memwrite/addr/din strobes and captures read data from dout.
- Returns a response (load data or store acknowledge) over a valid/ready handshake.

Parameters:
- ADDR_W, 4, data memory address width (16 words).
- DATA_W, 8, data word width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  core presents a request.
- req_ready  output  1  LSU can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  DATA_W  store data.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  core accepts the response.
- rsp_rdata  output  DATA_W  load data; 0 for store acknowledges.
- rsp_we  output  1  echoes req_we of the completed request.
- mem_read  output  1  to memory memread.
- mem_write  output  1  to memory memwrite.
- mem_addr  output  ADDR_W  to memory addr.
- mem_din  output  DATA_W  to memory din.
- mem_dout  input  DATA_W  from memory dout; combinational, valid while mem_read = 1.

Behaviour:
- FSM states:
  - IDLE: req_ready = 1.
  - RD: mem_read = 1.
  - WR: mem_write = 1.
  - RSP: rsp_valid = 1.
- Request and response capture:
  - Accept occurs when req_valid && req_ready, in IDLE only.
  - On accept, register addr_q, wdata_q and we_q.
  - Next state is WR if req_we, else RD.
- RD: exactly one cycle. mem_addr = addr_q. At the end of the cycle, rdata_q <= mem_dout. Next state RSP.
- WR: exactly one cycle. mem_addr = addr_q, mem_din = wdata_q. Memory commits at the closing edge. rdata_q <= 0. Next state RSP.
- RSP:
  - rsp_valid holds until rsp_ready is sampled high; then go to IDLE.
  - rsp_rdata and rsp_we stay stable while rsp_valid = 1.
- Latency: accept at edge N → mem strobe during cycle N+1 → rsp_valid from cycle N+2. Minimum 3 cycles per transaction; no overlap.
- req_ready = 0 in RD, WR and RSP; req_valid is ignored there.
- Memory-side outputs:
  - Decoded from registered state and registers only; no combinational path from req_* to mem_*.
  - Outside RD/WR: mem_read = 0, mem_write = 0, mem_addr = addr_q, mem_din = wdata_q.
- Reset (asynchronous, takes effect immediately):
  - state = IDLE; addr_q, wdata_q, rdata_q, we_q = 0.
  - Outputs: req_ready = 1, rsp_valid = 0, mem_read = 0, mem_write = 0, mem_addr = 0, mem_din = 0, rsp_rdata = 0, rsp_we = 0.
  - Reset asserted during WR deasserts mem_write asynchronously; that store may or may not commit, and no response is issued.
  - Reset during RSP drops the pending response.
- Address wrap: none; ADDR_W covers the full memory. Widths are fixed by parameters, with no arithmetic on the data path.

Optional Feature:
- Macro: DMEM_LSU_PERF_EN.
- When defined:
  - Adds outputs perf_rd_cnt [7:0] and perf_wr_cnt [7:0].
  - Each increments on leaving RD or WR respectively.
  - Both saturate at 255 and reset to 0.
- When undefined: neither the ports nor the counters exist; behaviour is otherwise identical.

Decomposition:
- Shared package/header cpu_pkg:
  - FSM state encodings LSU_IDLE=2'd0, LSU_RD=2'd1, LSU_WR=2'd2, LSU_RSP=2'd3.
  - ADDR_W/DATA_W defaults, shared with the data memory.
- No sub-module. With DMEM_LSU_PERF_EN, one optional sub-module sat_cnt8 (8-bit saturating counter, inc/clear) instanced twice.

Test Plan:
- Load with memory preloaded mem[0]=10: req_we=0, addr=0 → mem_read=1 for exactly one cycle at N+1, then rsp_valid=1 with rsp_rdata=8'd10 and rsp_we=0 at N+2.
- Store then load: store addr=5, wdata=8'hA5 → mem_write=1 for one cycle with mem_din=8'hA5, then ack with rsp_rdata=0 and rsp_we=1; follow-up load of addr 5 → rsp_rdata=8'hA5.
- Response backpressure: hold rsp_ready=0 for 4 cycles after a load of addr 1 (=10) → rsp_valid and rsp_rdata=10 held stable, req_ready=0, and a new req_valid is ignored; on rsp_ready=1 → IDLE next cycle, req_ready=1.
- Reset mid-write: assert rst during WR for addr 3, wdata 8'h55 → mem_write and rsp_valid drop immediately, req_ready=1 after release, and no response is ever seen.
- Back-to-back: keep req_valid=1 with 4 alternating store/load requests → exactly 4 responses in order, each ≥3 cycles apart, and mem_read/mem_write never both high.
- With DMEM_LSU_PERF_EN: 300 loads → perf_rd_cnt=255 (saturated), perf_wr_cnt=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data memory geometry and the load/store unit state encoding.
package cpu_pkg;

   localparam int CPU_ADDR_W = 4;
   localparam int CPU_DATA_W = 8;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_RD   = 2'd1,
      LSU_WR   = 2'd2,
      LSU_RSP  = 2'd3
   } lsu_state_e;

endpackage

// File: rtl/dmem_lsu_if.sv
// Core request/response handshake plus data memory strobes seen by dmem_lsu.
// The slave modport is the LSU; the master modport is the core plus memory side.
interface dmem_lsu_if
   import cpu_pkg::*;
#(
   parameter int ADDR_W = CPU_ADDR_W,
   parameter int DATA_W = CPU_DATA_W
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_we;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din;
   logic [DATA_W-1:0] mem_dout;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_dout,
      output req_ready, rsp_valid, rsp_rdata, rsp_we,
      output mem_read, mem_write, mem_addr, mem_din
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_dout,
      input  req_ready, rsp_valid, rsp_rdata, rsp_we,
      input  mem_read, mem_write, mem_addr, mem_din
   );
endinterface

// File: rtl/sat_cnt8.sv
// 8-bit saturating event counter with synchronous clear; only built when
// DMEM_LSU_PERF_EN is defined.
`ifdef DMEM_LSU_PERF_EN
module sat_cnt8 (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       inc,
   output logic [7:0] cnt
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= 8'd0;
      end else if (clear) begin
         cnt <= 8'd0;
      end else if (inc && cnt != 8'hFF) begin
         cnt <= cnt + 8'd1;
      end
   end
endmodule
`endif

// File: rtl/dmem_lsu.sv
// Single-outstanding load/store initiator between the core and data memory.
// Optional macro DMEM_LSU_PERF_EN adds saturating read/write performance counters.
module dmem_lsu
   import cpu_pkg::*;
#(
   parameter int ADDR_W = CPU_ADDR_W,
   parameter int DATA_W = CPU_DATA_W
) (
   input  logic       clk,
   input  logic       rst,
   dmem_lsu_if.slave  bus
`ifdef DMEM_LSU_PERF_EN
   ,
   output logic [7:0] perf_rd_cnt,
   output logic [7:0] perf_wr_cnt
`endif
);

   lsu_state_e        state_q;
   lsu_state_e        state_next;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              we_q;

   logic              req_ready_c;
   logic              rsp_valid_c;
   logic              mem_read_c;
   logic              mem_write_c;
   logic              accept;

   always_comb begin
      state_next  = state_q;
      req_ready_c = 1'b0;
      rsp_valid_c = 1'b0;
      mem_read_c  = 1'b0;
      mem_write_c = 1'b0;
      case (state_q)
         LSU_IDLE: begin
            req_ready_c = 1'b1;
            if (bus.req_valid) begin
               state_next = bus.req_we ? LSU_WR : LSU_RD;
            end
         end
         LSU_RD: begin
            mem_read_c = 1'b1;
            state_next = LSU_RSP;
         end
         LSU_WR: begin
            mem_write_c = 1'b1;
            state_next  = LSU_RSP;
         end
         LSU_RSP: begin
            rsp_valid_c = 1'b1;
            if (bus.rsp_ready) begin
               state_next = LSU_IDLE;
            end
         end
         default: state_next = LSU_IDLE;
      endcase
   end

   assign accept = req_ready_c && bus.req_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= LSU_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_next;
         if (accept) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            we_q    <= bus.req_we;
         end
         // Stores acknowledge with zero data so rsp_rdata never shows stale load data.
         if (state_q == LSU_RD) begin
            rdata_q <= bus.mem_dout;
         end else if (state_q == LSU_WR) begin
            rdata_q <= '0;
         end
      end
   end

   // Memory side is driven only from registers, never straight from req_*.
   assign bus.req_ready = req_ready_c;
   assign bus.rsp_valid = rsp_valid_c;
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_we    = we_q;
   assign bus.mem_read  = mem_read_c;
   assign bus.mem_write = mem_write_c;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_din   = wdata_q;

`ifdef DMEM_LSU_PERF_EN
   sat_cnt8 u_rd_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (1'b0),
      .inc   (state_q == LSU_RD),
      .cnt   (perf_rd_cnt)
   );

   sat_cnt8 u_wr_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (1'b0),
      .inc   (state_q == LSU_WR),
      .cnt   (perf_wr_cnt)
   );
`endif

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed scenarios plus random traffic against
// a timestamp-based transaction model and a reference copy of data memory.
module tb_dmem_lsu;
   import cpu_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dmem_lsu_if bus ();

`ifdef DMEM_LSU_PERF_EN
   logic [7:0] perf_rd;
   logic [7:0] perf_wr;
`endif

   dmem_lsu u_dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus)
`ifdef DMEM_LSU_PERF_EN
      ,
      .perf_rd_cnt (perf_rd),
      .perf_wr_cnt (perf_wr)
`endif
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      fails++;
      $display("FAIL %s: bound expired, got no event, expected one", name);
   endtask

   // Data memory: combinational read, write commits on the clock edge.
   logic [7:0] mem     [16];
   logic [7:0] pre_val [16];
   logic       preload = 1'b1;

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 16; i++) mem[i] <= pre_val[i];
      end else if (bus.mem_write) begin
         mem[bus.mem_addr] <= bus.mem_din;
      end
   end
   assign bus.mem_dout = mem[bus.mem_addr];

   // Transaction model: a request accepted at the edge closing cycle k strobes memory
   // in cycle k+1, responds from cycle k+2 until the handshake, then the LSU is idle.
   int         cyc = 0;
   bit         pending = 0;
   bit         p_we = 0;
   logic [3:0] p_addr = '0;
   logic [7:0] p_rdata = '0;
   int         acc_cyc = 0;
   logic [3:0] last_addr = '0;
   logic [7:0] last_wdata = '0;
   logic [7:0] ref_mem [16];
   int         resp_cnt = 0;
   int         last_hs = -1;
   int         m_rd = 0;
   int         m_wr = 0;

   always @(negedge clk) begin
      bit strobe;
      bit rv;
      cyc++;
      if (preload) begin
         for (int i = 0; i < 16; i++) ref_mem[i] = pre_val[i];
      end
      if (rst) begin
         // A store killed by reset may not have landed; resync from the memory itself.
         if (pending && p_we) ref_mem[p_addr] = mem[p_addr];
         pending    = 0;
         last_addr  = '0;
         last_wdata = '0;
         m_rd       = 0;
         m_wr       = 0;
      end
      strobe = pending && (cyc == acc_cyc + 1);
      rv     = pending && (cyc >= acc_cyc + 2);
      chk("req_ready", 32'(bus.req_ready), 32'(!pending));
      chk("mem_read", 32'(bus.mem_read), 32'(strobe && !p_we));
      chk("mem_write", 32'(bus.mem_write), 32'(strobe && p_we));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(rv));
      chk("mem_addr", 32'(bus.mem_addr), 32'(last_addr));
      chk("mem_din", 32'(bus.mem_din), 32'(last_wdata));
      if (bus.mem_read && bus.mem_write) chk("mem_rd_wr_exclusive", 32'(1), 32'(0));
      if (rv) begin
         chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(p_rdata));
         chk("rsp_we", 32'(bus.rsp_we), 32'(p_we));
      end
`ifdef DMEM_LSU_PERF_EN
      chk("perf_rd_cnt", 32'(perf_rd), 32'(m_rd));
      chk("perf_wr_cnt", 32'(perf_wr), 32'(m_wr));
`endif
      if (!rst) begin
         if (strobe && !p_we && m_rd < 255) m_rd++;
         if (strobe && p_we && m_wr < 255) m_wr++;
         if (rv && bus.rsp_ready) begin
            pending = 0;
            resp_cnt++;
            if (last_hs >= 0) chk("rsp_spacing_ge3", 32'(cyc - last_hs >= 3), 32'(1));
            last_hs = cyc;
         end else if (!pending && bus.req_valid) begin
            pending    = 1;
            acc_cyc    = cyc;
            p_we       = bus.req_we;
            p_addr     = bus.req_addr;
            last_addr  = bus.req_addr;
            last_wdata = bus.req_wdata;
            if (bus.req_we) begin
               p_rdata = 8'd0;
               ref_mem[bus.req_addr] = bus.req_wdata;
            end else begin
               p_rdata = ref_mem[bus.req_addr];
            end
         end
      end
   end

   // Present a request and return at posedge+1 of the accepting edge.
   task automatic issue(input bit we, input logic [3:0] a, input logic [7:0] d, input bit keep);
      bit ok;
      ok = 0;
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = a;
      bus.req_wdata = d;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (bus.req_ready) ok = 1;
      end
      @(posedge clk);
      #1;
      if (!keep) bus.req_valid = 1'b0;
      if (!ok) fail_now("accept_timeout");
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int seen;
      int base;
      rst = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 16; i++) pre_val[i] = 8'($urandom);
      pre_val[0] = 8'd10;
      pre_val[1] = 8'd10;
      #1 rst = 1'b1;
      #2;
      chk("reset_req_ready", 32'(bus.req_ready), 32'(1));
      chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'(0));
      chk("reset_mem_read", 32'(bus.mem_read), 32'(0));
      chk("reset_mem_write", 32'(bus.mem_write), 32'(0));
      chk("reset_mem_addr", 32'(bus.mem_addr), 32'(0));
      chk("reset_mem_din", 32'(bus.mem_din), 32'(0));
      chk("reset_rsp_rdata", 32'(bus.rsp_rdata), 32'(0));
      chk("reset_rsp_we", 32'(bus.rsp_we), 32'(0));
      repeat (3) @(posedge clk);
      #1;
      preload = 1'b0;
      rst = 1'b0;

      // Load of preloaded word 0.
      issue(1'b0, 4'd0, 8'd0, 1'b0);
      chk("ld0_mem_read_n1", 32'(bus.mem_read), 32'(1));
      step();
      chk("ld0_mem_read_n2", 32'(bus.mem_read), 32'(0));
      chk("ld0_rsp_valid", 32'(bus.rsp_valid), 32'(1));
      chk("ld0_rsp_rdata", 32'(bus.rsp_rdata), 32'(10));
      chk("ld0_rsp_we", 32'(bus.rsp_we), 32'(0));
      step();
      chk("ld0_idle", 32'(bus.req_ready), 32'(1));

      // Store then load back.
      issue(1'b1, 4'd5, 8'hA5, 1'b0);
      chk("st5_mem_write", 32'(bus.mem_write), 32'(1));
      chk("st5_mem_din", 32'(bus.mem_din), 32'(8'hA5));
      chk("st5_mem_addr", 32'(bus.mem_addr), 32'(5));
      step();
      chk("st5_ack_rdata", 32'(bus.rsp_rdata), 32'(0));
      chk("st5_ack_we", 32'(bus.rsp_we), 32'(1));
      step();
      issue(1'b0, 4'd5, 8'd0, 1'b0);
      step();
      chk("ld5_rsp_rdata", 32'(bus.rsp_rdata), 32'(8'hA5));
      step();

      // Response backpressure with a competing request that must be ignored.
      bus.rsp_ready = 1'b0;
      issue(1'b0, 4'd1, 8'd0, 1'b0);
      step();
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 4'd2;
      bus.req_wdata = 8'h77;
      repeat (4) begin
         step();
         chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'(1));
         chk("bp_rsp_rdata", 32'(bus.rsp_rdata), 32'(10));
         chk("bp_req_ready", 32'(bus.req_ready), 32'(0));
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      step();
      chk("bp_release_req_ready", 32'(bus.req_ready), 32'(1));
      chk("bp_release_rsp_valid", 32'(bus.rsp_valid), 32'(0));

      // Reset during the write cycle.
      issue(1'b1, 4'd3, 8'h55, 1'b0);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rstwr_mem_write", 32'(bus.mem_write), 32'(0));
      chk("rstwr_rsp_valid", 32'(bus.rsp_valid), 32'(0));
      chk("rstwr_req_ready", 32'(bus.req_ready), 32'(1));
      @(negedge clk);
      step();
      rst = 1'b0;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.rsp_valid) seen++;
      end
      chk("rstwr_no_response", 32'(seen), 32'(0));
      step();

`ifdef DMEM_LSU_PERF_EN
      chk("perf_rd_after_reset", 32'(perf_rd), 32'(0));
      for (int i = 0; i < 300; i++) issue(1'b0, 4'($urandom_range(0, 15)), 8'd0, 1'b0);
      repeat (3) step();
      chk("perf_rd_saturated", 32'(perf_rd), 32'(255));
      chk("perf_wr_zero", 32'(perf_wr), 32'(0));
`endif

      // Back-to-back: valid held high across four alternating requests.
      base = resp_cnt;
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 0) issue(1'b1, 4'(8 + k), 8'($urandom), 1'b1);
         else issue(1'b0, 4'(7 + k), 8'd0, 1'b1);
      end
      bus.req_valid = 1'b0;
      for (int i = 0; i < 100 && resp_cnt < base + 4; i++) @(posedge clk);
      repeat (4) step();
      chk("b2b_resp_count", 32'(resp_cnt - base), 32'(4));

      // Random traffic with random backpressure.
      for (int i = 0; i < 600; i++) begin
         step();
         bus.req_valid = 1'($urandom_range(0, 1));
         bus.req_we    = 1'($urandom_range(0, 1));
         bus.req_addr  = 4'($urandom_range(0, 15));
         bus.req_wdata = 8'($urandom);
         bus.rsp_ready = ($urandom_range(0, 9) < 7);
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      repeat (6) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
